instr_stream_loader: RTL and testbench
======================================

Name: instr_stream_loader

Overview:
- Sits directly upstream of the pipelined CPU and produces its `Reset`, `LoadInstructions` and `Instruction` inputs.
- Accepts a program as a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words in a local buffer.
- Then runs a reset / contiguous-burst / reset sequence so that the CPU's free-running load-address counter writes words 0..N-1 into instruction memory.
- Finally releases the CPU to run and holds it running until a new program is started.

Parameters:
DEPTH, 32, word capacity of program buffer (power of 2, >= 2)
CW, 6, width of word_count output; must satisfy 2**CW > DEPTH

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset of this block
rx_data  in  8  program byte
rx_valid  in  1  rx_data valid
rx_last  in  1  qualifies final byte of program (sampled with rx_valid)
rx_ready  out  1  block accepts byte this cycle
cpu_reset  out  1  drives CPU Reset
load_instructions  out  1  drives CPU LoadInstructions
instruction  out  32  drives CPU Instruction
word_count  out  CW  number of words stored for current program
busy  out  1  high in every state except IDLE and RUN
overflow  out  1  sticky, program exceeded DEPTH words

Behaviour:
Reset (async, active-high):
- Enters IDLE.
- cpu_reset=1, load_instructions=0, instruction=0, rx_ready=0, word_count=0, busy=0, overflow=0.
- Byte index and word pointer = 0.
- Buffer contents undefined.

State machine (registered outputs, all transitions on clk rising edge):
- IDLE: cpu_reset=1, rx_ready=1. On the first accepted byte, go to FILL; that byte is stored as byte 0.
- FILL: rx_ready=1, cpu_reset=1.
  - A byte is accepted when rx_valid and rx_ready are both high.
  - Byte k of a word goes to bits [31-8k:24-8k], k=0..3, so the first byte lands in [31:24].
  - When the 4th byte is accepted, the word is committed to buf[wptr], wptr increments and word_count increments.
  - If rx_last is accepted mid-word, the partial word is committed with the unfilled low bytes set to 0.
  - rx_last on an accepted byte moves to PRE_RST on the next cycle. rx_ready=0 from that cycle onward.
- Overflow: a word that would be committed when word_count==DEPTH is dropped; overflow is set and stays set until Reset or the next IDLE->FILL. Byte acceptance continues until rx_last.
- PRE_RST: exactly 1 cycle, cpu_reset=1, load_instructions=0. Clears the CPU load-address counter.
- BURST: exactly word_count cycles.
  - load_instructions=1, cpu_reset=0, instruction=buf[i] on cycle i (i=0..word_count-1).
  - Exactly one new word per clock with no gaps, because the CPU counter advances every clock.
- POST_RST: exactly 2 cycles, cpu_reset=1, load_instructions=0, instruction=0. Clears the PC and pipeline state disturbed during loading.
- RUN: cpu_reset=0, load_instructions=0, rx_ready=1.
  - Accepting a byte restarts the sequence: go to FILL, clear word_count and overflow, assert cpu_reset on that cycle, and store the byte as byte 0.

Timing:
- Load latency from the rx_last handshake to the first load_instructions=1 is 2 cycles (FILL->PRE_RST->BURST).
- RUN is reached 1+word_count+2 cycles after leaving FILL.

Boundary conditions:
- rx_last on the first byte gives a 1-word program.
- word_count==DEPTH is legal: BURST lasts DEPTH cycles.
- rx_valid with rx_ready=0 is ignored; the sender must hold the byte.
- Reset asserted mid-BURST aborts immediately: load_instructions drops asynchronously and the state goes to IDLE.
- busy = state in {FILL, PRE_RST, BURST, POST_RST}.

Test Plan:
- Stream 8 bytes 0x20,0x01,0x00,0x05, 0x20,0x02,0x00,0x07 with rx_last on the last byte -> word_count=2, then:
  - cpu_reset=1 for 1 cycle;
  - load_instructions=1 for exactly 2 cycles with instruction=0x20010005 then 0x20020007;
  - cpu_reset=1 for 2 cycles;
  - RUN with cpu_reset=0.
- Stream 5 bytes 0xAA,0xBB,0xCC,0xDD,0x11 with rx_last on the 5th -> words 0xAABBCCDD and 0x11000000, word_count=2.
- Stream (DEPTH+1)*4 bytes -> overflow=1, word_count=DEPTH, BURST lasts exactly DEPTH cycles with the first DEPTH words only.
- Throttle rx_valid at 1 byte per 3 cycles, and assert rx_valid during BURST -> rx_ready=0 outside IDLE/FILL/RUN, no byte lost or duplicated, packed words identical to the unthrottled case.
- Assert Reset on the 2nd BURST cycle -> load_instructions=0 and cpu_reset=1 before the next clk edge, state IDLE, word_count=0.
- From RUN, stream a new 1-byte program 0x3C -> cpu_reset rises on the accept cycle, overflow cleared, and a burst of 1 word 0x3C000000 follows.

Source files
------------

// File: rtl/instr_stream_loader_if.sv
// Byte-stream input and CPU-control outputs of the instruction stream loader.
// The master side is the sender or testbench. The slave side is the loader.
interface instr_stream_loader_if #(
  parameter int CW = 6
) ();
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_last;
  logic          rx_ready;
  logic          cpu_reset;
  logic          load_instructions;
  logic [31:0]   instruction;
  logic [CW-1:0] word_count;
  logic          busy;
  logic          overflow;

  modport master (
    output rx_data, rx_valid, rx_last,
    input  rx_ready, cpu_reset, load_instructions, instruction,
           word_count, busy, overflow
  );

  modport slave (
    input  rx_data, rx_valid, rx_last,
    output rx_ready, cpu_reset, load_instructions, instruction,
           word_count, busy, overflow
  );
endinterface

// File: rtl/instr_stream_loader.sv
// Packs a byte-stream program into words and then bursts it into the CPU's instruction memory.
// The burst runs inside a reset / load / reset sequence.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset; CPU held in reset, waiting for first byte
// FILL     | accepting bytes, packing big-endian words into buffer
// PRE_RST  | one reset cycle to clear the CPU load-address counter
// BURST    | one buffered word per clock with LoadInstructions high
// POST_RST | two reset cycles to clear PC/pipeline after loading
// RUN      | CPU released; a new byte restarts the sequence
module instr_stream_loader #(
  parameter int DEPTH = 32,
  parameter int CW    = 6
) (
  input  logic                   clk,
  input  logic                   Reset,
  instr_stream_loader_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PRE_RST,
    S_BURST,
    S_POST_RST,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic          post_q, post_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          load_q, load_d;
  logic [31:0]   instr_q, instr_d;
  logic          rx_ready_q, rx_ready_d;
  logic          busy_q, busy_d;

  logic [31:0]   buf_q [DEPTH];

  logic          accept;
  logic          start;
  logic [CW-1:0] wbase;
  logic [1:0]    kbase;
  logic [31:0]   abase;
  logic [31:0]   acc_new;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign accept = bus.rx_valid && rx_ready_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rptr_d  = rptr_q;
    bidx_d  = bidx_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    post_d  = post_q;
    instr_d = '0;
    wr_en   = 1'b0;
    wr_addr = '0;

    // A byte taken in IDLE or RUN begins a fresh program at byte 0 of word 0.
    start   = accept && ((state_q == S_IDLE) || (state_q == S_RUN));
    wbase   = start ? '0 : wcnt_q;
    kbase   = start ? 2'd0 : bidx_q;
    abase   = start ? '0 : acc_q;
    acc_new = abase | ({bus.rx_data, 24'h000000} >> {kbase, 3'b000});

    case (state_q)
      S_IDLE, S_FILL, S_RUN: begin
        if (accept) begin
          state_d = bus.rx_last ? S_PRE_RST : S_FILL;
          wcnt_d  = wbase;
          if (start) ovf_d = 1'b0;
          if (bus.rx_last || (kbase == 2'd3)) begin
            acc_d  = '0;
            bidx_d = '0;
            if (wbase == CW'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_addr = wbase[AW-1:0];
              wcnt_d  = wbase + CW'(1);
            end
          end else begin
            acc_d  = acc_new;
            bidx_d = kbase + 2'd1;
          end
        end
      end
      S_PRE_RST: begin
        post_d = 1'b0;
        rptr_d = '0;
        if (wcnt_q == '0) begin
          state_d = S_POST_RST;
        end else begin
          state_d = S_BURST;
          instr_d = buf_q[0];
          rptr_d  = CW'(1);
        end
      end
      S_BURST: begin
        // The CPU address counter advances every clock, so words go out with no gaps.
        if (rptr_q == wcnt_q) begin
          state_d = S_POST_RST;
          post_d  = 1'b0;
        end else begin
          instr_d = buf_q[rptr_q[AW-1:0]];
          rptr_d  = rptr_q + CW'(1);
        end
      end
      S_POST_RST: begin
        if (post_q) state_d = S_RUN;
        else        post_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    cpu_reset_d = (state_d != S_BURST) && (state_d != S_RUN);
    load_d      = (state_d == S_BURST);
    rx_ready_d  = (state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_RUN);
    busy_d      = (state_d == S_FILL) || (state_d == S_PRE_RST) ||
                  (state_d == S_BURST) || (state_d == S_POST_RST);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rptr_q      <= '0;
      bidx_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      post_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      load_q      <= 1'b0;
      instr_q     <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rptr_q      <= rptr_d;
      bidx_q      <= bidx_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      post_q      <= post_d;
      cpu_reset_q <= cpu_reset_d;
      load_q      <= load_d;
      instr_q     <= instr_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= acc_new;
  end

  assign bus.rx_ready          = rx_ready_q;
  assign bus.cpu_reset         = cpu_reset_q;
  assign bus.load_instructions = load_q;
  assign bus.instruction       = instr_q;
  assign bus.word_count        = wcnt_q;
  assign bus.busy              = busy_q;
  assign bus.overflow          = ovf_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Checks the loader against a byte-list / word-list model of the program.
// A per-cycle monitor compares every output. Directed programs pin the model with literal words.
module tb_instr_stream_loader;
  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  instr_stream_loader_if #(.CW(CW)) bus ();

  instr_stream_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {M_IDLE0, M_IDLE, M_FILL, M_LOAD, M_RUN} mmode_t;
  mmode_t      m_mode = M_IDLE0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_words[$];
  bit          m_ovf = 1'b0;
  int          m_t = 0;

  logic [7:0]  prog[$];
  logic [31:0] seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: the bytes of the program in big-endian order, zero-padded and truncated to DEPTH words.
  function automatic void pack();
    int nb, nw;
    logic [31:0] w;
    nb = m_bytes.size();
    nw = (nb + 3) / 4;
    m_words.delete();
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < nb) w[31-8*k -: 8] = m_bytes[4*i + k];
      if (i < DEPTH) m_words.push_back(w);
    end
    m_ovf = (nw > DEPTH);
  endfunction

  always @(negedge clk) begin
    logic e_rst, e_ld, e_rdy, e_busy, e_ovf;
    logic [31:0] e_ins;
    int e_wc, full, n;
    if (Reset) begin
      m_mode = M_IDLE0;
      m_bytes.delete();
      m_words.delete();
      m_ovf = 1'b0;
    end
    e_rst = 1'b1; e_ld = 1'b0; e_ins = '0; e_rdy = 1'b0; e_busy = 1'b0; e_wc = 0; e_ovf = 1'b0;
    n = m_words.size();
    case (m_mode)
      M_IDLE:  e_rdy = 1'b1;
      M_FILL: begin
        e_rdy  = 1'b1;
        e_busy = 1'b1;
        full   = m_bytes.size() / 4;
        e_wc   = (full > DEPTH) ? DEPTH : full;
        e_ovf  = (full > DEPTH);
      end
      M_LOAD: begin
        e_busy = 1'b1;
        e_wc   = n;
        e_ovf  = m_ovf;
        if (m_t >= 2 && m_t <= n + 1) begin
          e_rst = 1'b0;
          e_ld  = 1'b1;
          e_ins = m_words[m_t - 2];
        end
      end
      M_RUN: begin
        e_rst = 1'b0;
        e_rdy = 1'b1;
        e_wc  = n;
        e_ovf = m_ovf;
      end
      default: ;
    endcase
    n_checks++;
    if (bus.cpu_reset !== e_rst || bus.load_instructions !== e_ld || bus.instruction !== e_ins ||
        bus.rx_ready !== e_rdy || bus.busy !== e_busy || int'(bus.word_count) != e_wc ||
        bus.overflow !== e_ovf) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t actual rst=%b ld=%b ins=%h rdy=%b busy=%b wc=%0d ovf=%b required rst=%b ld=%b ins=%h rdy=%b busy=%b wc=%0d ovf=%b",
               $time, bus.cpu_reset, bus.load_instructions, bus.instruction, bus.rx_ready, bus.busy,
               bus.word_count, bus.overflow, e_rst, e_ld, e_ins, e_rdy, e_busy, e_wc, e_ovf);
    end
    if (bus.load_instructions === 1'b1) seen.push_back(bus.instruction);
    if (!Reset) begin
      case (m_mode)
        M_IDLE0: m_mode = M_IDLE;
        M_IDLE, M_FILL, M_RUN: begin
          if (e_rdy && bus.rx_valid) begin
            if (m_mode != M_FILL) m_bytes.delete();
            m_bytes.push_back(bus.rx_data);
            m_mode = M_FILL;
            if (bus.rx_last) begin
              pack();
              m_mode = M_LOAD;
              m_t = 1;
            end
          end
        end
        M_LOAD: begin
          m_t++;
          if (m_t > n + 3) m_mode = M_RUN;
        end
        default: ;
      endcase
    end
  end

  task automatic send_prog(input int gap, input bit junk);
    bit rdy;
    int waitc, nw;
    seen.delete();
    for (int i = 0; i < prog.size(); i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = prog[i];
      bus.rx_last  = (i == prog.size() - 1);
      waitc = 0;
      rdy = 1'b0;
      while (!rdy && waitc < 200) begin
        @(negedge clk);
        rdy = bus.rx_ready;
        @(posedge clk); #1;
        waitc++;
      end
      if (!rdy) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout actual=not_accepted required=accepted byte=%0d", i);
      end
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
      if (i != prog.size() - 1)
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
    if (junk) begin
      nw = (prog.size() + 3) / 4;
      if (nw > DEPTH) nw = DEPTH;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hEE;
      for (int j = 0; j < nw + 2; j++) begin @(posedge clk); #1; end
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic wait_run();
    int c = 0;
    while (m_mode != M_RUN && c < 400) begin @(posedge clk); #1; c++; end
    if (m_mode != M_RUN) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout actual=mode%0d required=RUN", m_mode);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic set_prog1();
    prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
  endtask

  task automatic check_prog1(input string tag);
    chk({tag, "_nwords"}, 32'(seen.size()), 32'd2);
    chk({tag, "_w0"}, seen[0], 32'h20010005);
    chk({tag, "_w1"}, seen[1], 32'h20020007);
    chk({tag, "_wc"}, 32'(bus.word_count), 32'd2);
    chk({tag, "_run_rst"}, 32'(bus.cpu_reset), 32'd0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.rx_last  = 1'b0;

    @(posedge clk); #1;
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_load", 32'(bus.load_instructions), 32'd0);
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_wc", 32'(bus.word_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;

    set_prog1();
    send_prog(0, 1'b0);
    wait_run();
    check_prog1("p1");

    set_prog1();
    send_prog(2, 1'b1);
    wait_run();
    check_prog1("p1thr");

    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    send_prog(0, 1'b0);
    wait_run();
    chk("p2_nwords", 32'(seen.size()), 32'd2);
    chk("p2_w0", seen[0], 32'hAABBCCDD);
    chk("p2_w1", seen[1], 32'h11000000);
    chk("p2_wc", 32'(bus.word_count), 32'd2);

    prog.delete();
    for (int i = 0; i < (DEPTH + 1) * 4; i++) prog.push_back(8'($urandom));
    send_prog(0, 1'b0);
    wait_run();
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_wc", 32'(bus.word_count), 32'(DEPTH));
    chk("ovf_nwords", 32'(seen.size()), 32'(DEPTH));
    chk("ovf_first", seen[0], {prog[0], prog[1], prog[2], prog[3]});
    chk("ovf_last", seen[DEPTH-1], {prog[4*DEPTH-4], prog[4*DEPTH-3], prog[4*DEPTH-2], prog[4*DEPTH-1]});

    prog = '{8'h3C};
    send_prog(0, 1'b0);
    chk("restart_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("restart_ovf", 32'(bus.overflow), 32'd0);
    wait_run();
    chk("restart_nwords", 32'(seen.size()), 32'd1);
    chk("restart_w0", seen[0], 32'h3C000000);

    for (int r = 0; r < 8; r++) begin
      int nb;
      nb = $urandom_range(1, 60);
      prog.delete();
      for (int i = 0; i < nb; i++) prog.push_back(8'($urandom));
      send_prog($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      wait_run();
    end

    prog.delete();
    for (int i = 0; i < 12; i++) prog.push_back(8'($urandom));
    send_prog(0, 1'b0);
    begin
      int c = 0;
      @(negedge clk);
      while (bus.load_instructions !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (bus.load_instructions !== 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL burst_wait actual=no_burst required=burst");
      end
    end
    @(posedge clk); #2;
    Reset = 1'b1;
    #1;
    chk("abort_load", 32'(bus.load_instructions), 32'd0);
    chk("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("abort_wc", 32'(bus.word_count), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_instr", bus.instruction, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;

    set_prog1();
    send_prog(1, 1'b1);
    wait_run();
    check_prog1("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
